// File: rtl/esm_pkg.sv
// esm_pkg: definitions shared by the ESM issue path and ESM-side checkers.
//   - RV32 opcode constants recognised by the control decoder
//   - NOP_WORD bubble instruction (addi x0,x0,0)
//   - instruction field slice positions
//   - issue-slot selection used by the feeder's output register
package esm_pkg;

    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_LD  = 7'b0000011;
    localparam logic [6:0] OP_ST  = 7'b0100011;
    localparam logic [6:0] OP_BR  = 7'b1100011;
    localparam logic [6:0] OP_LUI = 7'b0110111;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    localparam logic [31:0] NOP_WORD = 32'h00000013;

    localparam int unsigned OPC_MSB = 6;
    localparam int unsigned OPC_LSB = 0;
    localparam int unsigned RD_MSB  = 11;
    localparam int unsigned RD_LSB  = 7;
    localparam int unsigned RS1_MSB = 19;
    localparam int unsigned RS1_LSB = 15;
    localparam int unsigned RS2_MSB = 24;
    localparam int unsigned RS2_LSB = 20;

    // What the issue register loads on the coming edge.
    typedef enum logic [1:0] {
        ISS_KEEP   = 2'd0,
        ISS_POP    = 2'd1,
        ISS_BUBBLE = 2'd2
    } issue_sel_e;

endpackage

// File: rtl/esm_ctrl_decode.sv
// esm_ctrl_decode: purely combinational opcode -> control decode.
// Ports:
//   opcode_i   [6:0]  instruction opcode field
//   RegWrite_o        destination register write enable
//   ALUSrc_o          ALU operand B takes the immediate
// Unknown opcodes decode to no write and register operand.
module esm_ctrl_decode
    import esm_pkg::*;
(
    input  logic [6:0] opcode_i,
    output logic       RegWrite_o,
    output logic       ALUSrc_o
);

    always_comb begin
        RegWrite_o = 1'b0;
        ALUSrc_o   = 1'b0;
        unique case (opcode_i)
            OP_R:    begin RegWrite_o = 1'b1; ALUSrc_o = 1'b0; end
            OP_I:    begin RegWrite_o = 1'b1; ALUSrc_o = 1'b1; end
            OP_LD:   begin RegWrite_o = 1'b1; ALUSrc_o = 1'b1; end
            OP_ST:   begin RegWrite_o = 1'b0; ALUSrc_o = 1'b1; end
            OP_BR:   begin RegWrite_o = 1'b0; ALUSrc_o = 1'b0; end
            OP_LUI:  begin RegWrite_o = 1'b1; ALUSrc_o = 1'b1; end
            OP_JAL:  begin RegWrite_o = 1'b1; ALUSrc_o = 1'b0; end
            default: begin RegWrite_o = 1'b0; ALUSrc_o = 1'b0; end
        endcase
    end

endmodule

// File: rtl/esm_issue_feeder.sv
// esm_issue_feeder: FIFO-buffered instruction source for the ESM scheduler.
// Accepts words from the loader over in_valid/in_ready and issues one registered
// instruction per unheld clock, with decoded RegWrite/ALUSrc. An empty FIFO issues
// the NOP bubble with issue_valid=0. There is no empty bypass: minimum latency is
// two edges from acceptance to Instr_out.
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   in_valid, in_instr    loader word and its valid
//   in_ready              FIFO not full (from registered count)
//   hold                  freeze issue; pushes still proceed
//   flush                 empty the FIFO and issue a bubble; beats push/pop/hold
//   Instr_out             instruction towards ESM Instr_in
//   RegWrite, ALUSrc      decode of Instr_out
//   issue_valid           Instr_out is a real instruction
//   fifo_count            current occupancy
module esm_issue_feeder #(
    parameter int unsigned Instruction_word_size = 32,
    parameter int unsigned DEPTH                 = 8,
    parameter logic [Instruction_word_size-1:0] NOP_WORD = esm_pkg::NOP_WORD
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             in_valid,
    input  logic [Instruction_word_size-1:0] in_instr,
    output logic                             in_ready,
    input  logic                             hold,
    input  logic                             flush,
    output logic [Instruction_word_size-1:0] Instr_out,
    output logic                             RegWrite,
    output logic                             ALUSrc,
    output logic                             issue_valid,
    output logic [$clog2(DEPTH):0]           fifo_count
);

    import esm_pkg::*;

    localparam int unsigned W  = Instruction_word_size;
    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;

    logic [W-1:0]  instr_q, instr_d;
    logic          regwrite_q, regwrite_d;
    logic          alusrc_q, alusrc_d;
    logic          valid_q, valid_d;

    logic          push;
    logic          pop;
    logic [W-1:0]  head_word;
    logic          head_rw;
    logic          head_as;
    issue_sel_e    sel;

    assign in_ready   = (count_q != FULL_CNT);
    assign fifo_count = count_q;

    assign Instr_out   = instr_q;
    assign RegWrite    = regwrite_q;
    assign ALUSrc      = alusrc_q;
    assign issue_valid = valid_q;

    // in_ready comes from the registered count, so a pop while full cannot make
    // room for a push on the same edge.
    assign push = in_valid && in_ready && !flush;
    assign pop  = !flush && !hold && (count_q != '0);

    assign head_word = mem_q[rd_ptr_q];

    esm_ctrl_decode u_decode (
        .opcode_i   (head_word[OPC_MSB:OPC_LSB]),
        .RegWrite_o (head_rw),
        .ALUSrc_o   (head_as)
    );

    // ---------------- FIFO pointers and occupancy ----------------
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            unique case ({push, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage carries no reset; contents are meaningless until written.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= in_instr;
    end

    // ---------------- issue register ----------------
    always_comb begin
        sel = ISS_KEEP;
        if (flush) begin
            sel = ISS_BUBBLE;
        end else if (!hold) begin
            sel = (count_q != '0) ? ISS_POP : ISS_BUBBLE;
        end
    end

    always_comb begin
        instr_d    = instr_q;
        regwrite_d = regwrite_q;
        alusrc_d   = alusrc_q;
        valid_d    = valid_q;
        unique case (sel)
            ISS_POP: begin
                instr_d    = head_word;
                regwrite_d = head_rw;
                alusrc_d   = head_as;
                valid_d    = 1'b1;
            end
            ISS_BUBBLE: begin
                instr_d    = NOP_WORD;
                regwrite_d = 1'b0;
                alusrc_d   = 1'b0;
                valid_d    = 1'b0;
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            instr_q    <= NOP_WORD;
            regwrite_q <= 1'b0;
            alusrc_q   <= 1'b0;
            valid_q    <= 1'b0;
        end else begin
            instr_q    <= instr_d;
            regwrite_q <= regwrite_d;
            alusrc_q   <= alusrc_d;
            valid_q    <= valid_d;
        end
    end

endmodule

// File: tb/tb_esm_issue_feeder.sv
// Testbench for esm_issue_feeder: queue-based reference model compared on every
// negative clock edge, directed scenarios with literal expectations, then a
// randomized phase.
module tb_esm_issue_feeder;

    localparam int unsigned DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [31:0] in_instr = '0;
    logic        hold = 1'b0;
    logic        flush = 1'b0;
    logic        in_ready;
    logic [31:0] Instr_out;
    logic        RegWrite;
    logic        ALUSrc;
    logic        issue_valid;
    logic [3:0]  fifo_count;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;
    logic        cmp_en = 1'b0;

    esm_issue_feeder #(
        .Instruction_word_size (32),
        .DEPTH                 (DEPTH),
        .NOP_WORD              (32'h00000013)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_instr    (in_instr),
        .in_ready    (in_ready),
        .hold        (hold),
        .flush       (flush),
        .Instr_out   (Instr_out),
        .RegWrite    (RegWrite),
        .ALUSrc      (ALUSrc),
        .issue_valid (issue_valid),
        .fifo_count  (fifo_count)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    logic [31:0] mq[$];
    logic [31:0] m_instr = 32'h00000013;
    logic        m_rw = 1'b0;
    logic        m_as = 1'b0;
    logic        m_v  = 1'b0;

    // Decode table for opcodes -> {RegWrite, ALUSrc}.
    function automatic logic [1:0] ref_decode(input logic [31:0] w);
        logic [6:0] op;
        op = w[6:0];
        case (op)
            7'b0110011: return 2'b10;
            7'b0010011: return 2'b11;
            7'b0000011: return 2'b11;
            7'b0100011: return 2'b01;
            7'b1100011: return 2'b00;
            7'b0110111: return 2'b11;
            7'b1101111: return 2'b10;
            default:    return 2'b00;
        endcase
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mq.delete();
            m_instr = 32'h00000013; m_rw = 1'b0; m_as = 1'b0; m_v = 1'b0;
        end else if (flush) begin
            mq.delete();
            m_instr = 32'h00000013; m_rw = 1'b0; m_as = 1'b0; m_v = 1'b0;
        end else begin
            bit          accept;
            logic [1:0]  d;
            logic [31:0] w;
            accept = in_valid && (mq.size() < DEPTH);
            if (!hold) begin
                if (mq.size() > 0) begin
                    w = mq.pop_front();
                    d = ref_decode(w);
                    m_instr = w; m_rw = d[1]; m_as = d[0]; m_v = 1'b1;
                end else begin
                    m_instr = 32'h00000013; m_rw = 1'b0; m_as = 1'b0; m_v = 1'b0;
                end
            end
            if (accept) mq.push_back(in_instr);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (cmp_en && !rst) begin
            chk("model.Instr_out",   Instr_out,          m_instr);
            chk("model.RegWrite",    {31'b0, RegWrite},  {31'b0, m_rw});
            chk("model.ALUSrc",      {31'b0, ALUSrc},    {31'b0, m_as});
            chk("model.issue_valid", {31'b0, issue_valid}, {31'b0, m_v});
            chk("model.in_ready",    {31'b0, in_ready},  {31'b0, (mq.size() != DEPTH)});
            chk("model.fifo_count",  {28'b0, fifo_count}, 32'(mq.size()));
        end
    end

    // Each step: clock edge, then inputs/literal checks 2 time units later.
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic chk_out(input string name, input logic [31:0] ins,
                           input logic rw, input logic as, input logic v);
        chk({name, ".Instr_out"},   Instr_out, ins);
        chk({name, ".RegWrite"},    {31'b0, RegWrite}, {31'b0, rw});
        chk({name, ".ALUSrc"},      {31'b0, ALUSrc}, {31'b0, as});
        chk({name, ".issue_valid"}, {31'b0, issue_valid}, {31'b0, v});
    endtask

    logic [31:0] words [8];
    logic [1:0]  ctl   [8];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected end before 200000");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] r;
        logic [6:0]  opc [8];

        words[0] = 32'h003100B3; ctl[0] = 2'b10;  // add x1,x2,x3
        words[1] = 32'h00500093; ctl[1] = 2'b11;  // addi x1,x0,5
        words[2] = 32'h0000A103; ctl[2] = 2'b11;  // lw x2,0(x1)
        words[3] = 32'h0020A223; ctl[3] = 2'b01;  // sw x2,4(x1)
        words[4] = 32'h00208463; ctl[4] = 2'b00;  // beq x1,x2,8
        words[5] = 32'h000011B7; ctl[5] = 2'b11;  // lui x3,1
        words[6] = 32'h0080006F; ctl[6] = 2'b10;  // jal x0,8
        words[7] = 32'h00000000; ctl[7] = 2'b00;

        // 1. reset
        step();
        step();
        rst = 1'b0;
        cmp_en = 1'b1;
        step();
        chk_out("reset", 32'h00000013, 1'b0, 1'b0, 1'b0);
        chk("reset.in_ready", {31'b0, in_ready}, 32'd1);
        chk("reset.fifo_count", {28'b0, fifo_count}, 32'd0);

        // 2. single word, two-edge latency
        in_valid = 1'b1; in_instr = 32'h003100B3;
        step();
        in_valid = 1'b0;
        chk("single.not_yet", {31'b0, issue_valid}, 32'd0);
        step();
        chk_out("single", 32'h003100B3, 1'b1, 1'b0, 1'b1);
        step();
        chk_out("single.bubble", 32'h00000013, 1'b0, 1'b0, 1'b0);

        // 3. fill under hold, then drain in order
        hold = 1'b1;
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1; in_instr = words[i];
            step();
        end
        in_instr = 32'hDEADBEEF;      // offered while full: must not be taken
        step();
        in_valid = 1'b0;
        chk("full.fifo_count", {28'b0, fifo_count}, 32'd8);
        chk("full.in_ready", {31'b0, in_ready}, 32'd0);
        hold = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step();
            chk_out($sformatf("drain%0d", i), words[i], ctl[i][1], ctl[i][0], 1'b1);
        end
        step();
        chk_out("drain.bubble", 32'h00000013, 1'b0, 1'b0, 1'b0);

        // 4. streaming: continuous push, count never above 1
        for (int i = 0; i < 20; i++) begin
            in_valid = 1'b1; in_instr = {12'hA5A, 8'(i), 5'd1, 7'b0010011};
            step();
            chk("stream.count_le1", {31'b0, (fifo_count <= 4'd1)}, 32'd1);
        end
        in_valid = 1'b0;
        step();
        step();

        // 5. flush with count=5 and a word on the flush edge
        hold = 1'b1;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; in_instr = words[i];
            step();
        end
        chk("preflush.fifo_count", {28'b0, fifo_count}, 32'd5);
        in_instr = 32'h12345037; flush = 1'b1;
        step();
        flush = 1'b0; in_valid = 1'b0; hold = 1'b0;
        chk("flush.fifo_count", {28'b0, fifo_count}, 32'd0);
        chk("flush.in_ready", {31'b0, in_ready}, 32'd1);
        chk_out("flush", 32'h00000013, 1'b0, 1'b0, 1'b0);
        step();
        chk("flush.dropped", {31'b0, issue_valid}, 32'd0);
        in_valid = 1'b1; in_instr = words[5];
        step();
        in_valid = 1'b0;
        step();
        chk_out("flush.resume", words[5], 1'b1, 1'b1, 1'b1);

        // 6. asynchronous reset mid-cycle with count=3
        hold = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_instr = words[i];
            step();
        end
        in_valid = 1'b0;
        step();
        chk_out("prerst", words[5], 1'b1, 1'b1, 1'b1);
        chk("prerst.fifo_count", {28'b0, fifo_count}, 32'd3);
        rst = 1'b1;
        #1;
        chk_out("asyncrst", 32'h00000013, 1'b0, 1'b0, 1'b0);
        chk("asyncrst.fifo_count", {28'b0, fifo_count}, 32'd0);
        chk("asyncrst.in_ready", {31'b0, in_ready}, 32'd1);
        hold = 1'b0;
        step();
        rst = 1'b0;
        in_valid = 1'b1; in_instr = words[6];
        step();
        in_valid = 1'b0;
        step();
        chk_out("postrst", words[6], 1'b1, 1'b0, 1'b1);

        // 7. randomized traffic against the model
        opc[0] = 7'b0110011; opc[1] = 7'b0010011; opc[2] = 7'b0000011; opc[3] = 7'b0100011;
        opc[4] = 7'b1100011; opc[5] = 7'b0110111; opc[6] = 7'b1101111; opc[7] = 7'b1110011;
        for (int i = 0; i < 600; i++) begin
            r = $urandom();
            in_valid = ($urandom_range(0, 99) < 60);
            hold     = ($urandom_range(0, 99) < 25);
            flush    = ($urandom_range(0, 99) < 3);
            if ($urandom_range(0, 7) == 0) in_instr = r;
            else in_instr = {r[31:7], opc[$urandom_range(0, 7)]};
            step();
        end
        in_valid = 1'b0; hold = 1'b0; flush = 1'b0;
        for (int i = 0; i < 12; i++) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
